// File: rtl/fifo_buffer_acc_param.sv
// Partial-sum FIFO with occupancy, almost-full and sticky error flags.
// Define FIFO_ACC_SAT_EN for signed-saturating accumulate (default wraps).
module fifo_buffer_acc_param #(
  parameter int DataWidth        = 32,
  parameter int Depth            = 4,
  parameter int AlmostFullThresh = Depth - 1
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       Push,
  input  logic                       Pop,
  input  logic                       Acc,
  input  logic                       ClearErr,
  input  logic [DataWidth-1:0]       DataIn,
  output logic [DataWidth-1:0]       DataOut,
  output logic                       Empty,
  output logic                       Full,
  output logic                       AlmostFull,
  output logic [$clog2(Depth):0]     Count,
  output logic                       Overflow,
  output logic                       Underflow
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [DataWidth-1:0] mem [Depth];
  logic [AW-1:0]        rd;
  logic [AW-1:0]        wr;
  logic [CW-1:0]        cnt;
  logic                 ovf;
  logic                 unf;

  logic                 do_pop;
  logic                 do_push;
  logic                 acc_go;
  logic                 ovf_evt;
  logic                 unf_evt;
  logic [DataWidth-1:0] head;
  logic [DataWidth-1:0] sum;
  logic [DataWidth-1:0] acc_val;
  logic [DataWidth-1:0] wdata;
  logic [CW-1:0]        cnt_nxt;

  assign Empty      = (cnt == '0);
  assign Full       = (cnt == CW'(Depth));
  assign AlmostFull = (cnt >= CW'(AlmostFullThresh));
  assign Count      = cnt;
  assign Overflow   = ovf;
  assign Underflow  = unf;

  assign head    = mem[rd];
  assign DataOut = Empty ? '0 : head;

  // Request qualification: a pop on a full FIFO frees the slot for a push.
  always_comb begin
    do_pop  = Pop & ~Empty;
    do_push = Push & (~Full | do_pop);
    acc_go  = Acc & Push & do_pop;
    ovf_evt = Push & ~do_push;
    unf_evt = Pop & Empty;
    cnt_nxt = cnt + CW'(do_push) - CW'(do_pop);
  end

  // Accumulate adder: wraps by default, clamps when saturation is enabled.
  always_comb begin
    sum     = head + DataIn;
    acc_val = sum;
`ifdef FIFO_ACC_SAT_EN
    if ((head[DataWidth-1] == DataIn[DataWidth-1]) &&
        (sum[DataWidth-1] != head[DataWidth-1])) begin
      acc_val = head[DataWidth-1]
              ? {1'b1, {(DataWidth-1){1'b0}}}
              : {1'b0, {(DataWidth-1){1'b1}}};
    end
`endif
    wdata = acc_go ? acc_val : DataIn;
  end

  // Storage, pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr] <= wdata;
        wr      <= wr + AW'(1);
      end
      if (do_pop) rd <= rd + AW'(1);
      cnt <= cnt_nxt;
      ovf <= ovf_evt | (ovf & ~ClearErr);
      unf <= unf_evt | (unf & ~ClearErr);
    end
  end

endmodule
